// File: rtl/uk101_vram_arbiter.sv
// Single-port video RAM arbiter: fixed-latency scan-out fetch has priority,
// the CPU req/ack port fills the free RAM cycles.
module uk101_vram_arbiter #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              clk_pixel,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_starve,
    input  logic              starve_clr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_WR   = 2'd1,
        C_RD   = 2'd2
    } cpu_state_t;

    localparam logic [7:0] LIMIT_C = 8'(STARVE_LIMIT);

    cpu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;
    logic              vid_valid_q, vid_valid_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              cpu_starve_q, cpu_starve_d;
    logic [7:0]        starve_cnt_q, starve_cnt_d;
    logic              tag1_vld_q, tag1_vld_d, tag1_cpu_q, tag1_cpu_d;
    logic              tag2_vld_q, tag2_vld_d, tag2_cpu_q, tag2_cpu_d;
    logic              grant_s;
    logic              cpu_rd_inflight_s;

    // Next-state logic: issue slot, read-return routing, CPU FSM and starvation tracking
    always_comb begin
        state_d      = state_q;
        ram_addr_d   = ram_addr_q;
        ram_we_d     = 1'b0;
        ram_wdata_d  = ram_wdata_q;
        vid_data_d   = vid_data_q;
        vid_valid_d  = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        cpu_ack_d    = 1'b0;
        cpu_starve_d = cpu_starve_q;
        starve_cnt_d = starve_cnt_q;
        tag1_vld_d   = 1'b0;
        tag1_cpu_d   = 1'b0;
        tag2_vld_d   = tag1_vld_q;
        tag2_cpu_d   = tag1_cpu_q;

        grant_s           = (state_q == C_IDLE) && cpu_req && !vid_req;
        cpu_rd_inflight_s = (tag1_vld_q && tag1_cpu_q) || (tag2_vld_q && tag2_cpu_q);

        if (vid_req) begin
            ram_addr_d = vid_addr;
            tag1_vld_d = 1'b1;
            tag1_cpu_d = 1'b0;
        end else if (grant_s) begin
            ram_addr_d = cpu_addr;
            if (cpu_we) begin
                ram_we_d    = 1'b1;
                ram_wdata_d = cpu_wdata;
                cpu_ack_d   = 1'b1;
            end else begin
                tag1_vld_d = 1'b1;
                tag1_cpu_d = 1'b1;
            end
        end else begin
            ram_addr_d = ram_addr_q;
        end

        // The tag that left stage 2 names the owner of this cycle's ram_rdata
        if (tag2_vld_q) begin
            if (tag2_cpu_q) begin
                cpu_rdata_d = ram_rdata;
                cpu_ack_d   = 1'b1;
            end else begin
                vid_data_d  = ram_rdata;
                vid_valid_d = 1'b1;
            end
        end else begin
            vid_valid_d = 1'b0;
        end

        case (state_q)
            C_IDLE: begin
                if (grant_s) begin
                    state_d = cpu_we ? C_WR : C_RD;
                end else begin
                    state_d = C_IDLE;
                end
            end
            C_WR: state_d = C_IDLE;
            // Stay busy through the ack cycle so a held request is not regranted
            C_RD: begin
                if (cpu_rd_inflight_s) begin
                    state_d = C_RD;
                end else begin
                    state_d = C_IDLE;
                end
            end
            default: state_d = C_IDLE;
        endcase

        if (grant_s) begin
            starve_cnt_d = 8'd0;
        end else if ((state_q == C_IDLE) && cpu_req && (starve_cnt_q != 8'd255)) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end

        if (starve_cnt_q == LIMIT_C) begin
            cpu_starve_d = 1'b1;
        end else if (starve_clr) begin
            cpu_starve_d = 1'b0;
        end else begin
            cpu_starve_d = cpu_starve_q;
        end
    end

    // State and output registers; reset discards any in-flight reads
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= C_IDLE;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_wdata_q  <= '0;
            vid_data_q   <= '0;
            vid_valid_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            cpu_starve_q <= 1'b0;
            starve_cnt_q <= 8'd0;
            tag1_vld_q   <= 1'b0;
            tag1_cpu_q   <= 1'b0;
            tag2_vld_q   <= 1'b0;
            tag2_cpu_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ram_addr_q   <= ram_addr_d;
            ram_we_q     <= ram_we_d;
            ram_wdata_q  <= ram_wdata_d;
            vid_data_q   <= vid_data_d;
            vid_valid_q  <= vid_valid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_starve_q <= cpu_starve_d;
            starve_cnt_q <= starve_cnt_d;
            tag1_vld_q   <= tag1_vld_d;
            tag1_cpu_q   <= tag1_cpu_d;
            tag2_vld_q   <= tag2_vld_d;
            tag2_cpu_q   <= tag2_cpu_d;
        end
    end

    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_wdata  = ram_wdata_q;
    assign vid_data   = vid_data_q;
    assign vid_valid  = vid_valid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_ack    = cpu_ack_q;
    assign cpu_starve = cpu_starve_q;

endmodule

// File: doc/uk101_vram_arbiter.md
Name: uk101_vram_arbiter

Overview:
- Shares one single-port synchronous display RAM between two requesters:
  - the HDMI/VGA text scan-out fetch, which has fixed priority and fixed latency;
  - the CPU bus, which uses a req/ack handshake with wait states.
- Sits between the text display generator (its dispAddr/dispData path) and the 2K/8K video RAM.
- The scan-out always sees deterministic read latency. CPU accesses fill the free RAM cycles.

Parameters:
- ADDR_W, 13, address width of RAM, video and CPU ports.
- DATA_W, 8, data width.
- STARVE_LIMIT, 64, consecutive CPU wait cycles after which cpu_starve sets; range 1..255.

Ports:
- clk_pixel  in  1  pixel clock (25 MHz); all logic on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- vid_req  in  1  one-cycle video fetch strobe.
- vid_addr  in  ADDR_W  video fetch address, sampled with vid_req.
- vid_data  out  DATA_W  fetched byte.
- vid_valid  out  1  one-cycle pulse, vid_data valid.
- cpu_req  in  1  CPU request level, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req.
- cpu_addr  in  ADDR_W  CPU address; stable while cpu_req.
- cpu_wdata  in  DATA_W  CPU write data; stable while cpu_req.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data, valid while cpu_ack=1.
- cpu_starve  out  1  sticky starvation flag.
- starve_clr  in  1  synchronous clear of cpu_starve.
- ram_addr  out  ADDR_W  RAM address, registered.
- ram_we  out  1  RAM write enable, registered.
- ram_wdata  out  DATA_W  RAM write data, registered.
- ram_rdata  in  DATA_W  RAM read data; valid the cycle after the address cycle (1-cycle sync read).

Behaviour:
- Reset (async assert, sync release): clears every output register and all state to 0, giving:
  - ram_addr=0, ram_we=0, ram_wdata=0;
  - vid_valid=0, vid_data=0;
  - cpu_ack=0, cpu_rdata=0, cpu_starve=0;
  - state C_IDLE; tag pipeline empty.
- Issue slot: at most one RAM access is issued per cycle. Priority is evaluated every cycle from the inputs sampled at the rising edge.
- Video issue: vid_req=1 at edge ending cycle N loads ram_addr<=vid_addr and ram_we<=0 (visible cycle N+1).
  - ram_rdata is valid in cycle N+2 and is registered into vid_data.
  - vid_valid=1 exactly in cycle N+3.
  - Latency is fixed at 3 and is independent of CPU activity.
  - Back-to-back vid_req on consecutive cycles is fully pipelined.
- CPU FSM states:
  - C_IDLE:
    - cpu_req=1 and vid_req=0: grant (issue the CPU access).
      - Write goes to C_WR.
      - Read goes to C_RD.
    - cpu_req=1 and vid_req=1: no grant; stay in C_IDLE (CPU waits).
  - C_WR: issue cycle has ram_we=1, ram_addr=cpu_addr, ram_wdata=cpu_wdata. cpu_ack=1 in that same cycle (grant edge +1). Returns to C_IDLE.
  - C_RD: address issued at grant edge. ram_rdata is captured into cpu_rdata; cpu_ack=1 in cycle grant+3. Returns to C_IDLE on the ack edge.
  - A new grant is never issued while in C_WR or C_RD, even if cpu_req stays high.
  - A request still high in the cycle after ack is treated as a new request.
- Tag pipeline: a 2-stage shift of {valid, owner} routes ram_rdata to the video or CPU capture register. In-flight reads of both owners may overlap; ordering is preserved.
- ram_we returns to 0 in every non-CPU-write cycle. ram_addr holds its last value when idle.
- Read-after-write: a write to address A followed by any later read of A (either owner) returns the new data.
- Starvation counter (8-bit):
  - Increments each cycle cpu_req=1 in C_IDLE without a grant.
  - Clears on grant. Saturates at 255.
  - When count==STARVE_LIMIT, cpu_starve<=1. It stays set until starve_clr=1 or reset.
  - starve_clr and a set in the same cycle: the set wins.
- Reset mid-operation: in-flight reads are discarded. No vid_valid or cpu_ack is produced for them after release.
- No illegal or unused FSM state persists: any unused encoding returns to C_IDLE.

Test Plan:
1. Video only: vid_req pulses at cycles 10, 18, 26 with addresses 0x000/0x001/0x002, RAM preloaded 0x41/0x42/0x43 -> vid_valid at 13, 21, 29 with vid_data 0x41, 0x42, 0x43; ram_we stays 0.
2. CPU write then read: cpu_req with we=1, addr 0x0123, wdata 0x5A at cycle 5, no video -> ram_we=1 cycle 6, cpu_ack cycle 6. Then read of 0x0123 -> cpu_ack with cpu_rdata=0x5A 3 cycles after grant.
3. Collision: vid_req and cpu_req (read 0x0010) together at cycle 20, vid_req again at 21 -> video served at 20 and 21. CPU granted at 22; vid_valid at 23 and 24; cpu_ack at 25. Video latency stays 3.
4. Starvation: STARVE_LIMIT=4, vid_req held high for 10 cycles with cpu_req high -> cpu_starve rises after 4 wait cycles. CPU is granted on the first cycle vid_req=0. cpu_starve stays 1 until a starve_clr pulse.
5. Reset mid-read: CPU read granted at cycle 30, reset_n low at cycle 31 for 2 cycles -> no cpu_ack or vid_valid after release; all outputs 0; the next request completes normally.
6. Interleaved pipeline: alternate vid_req/CPU reads every cycle for 16 cycles over random addresses -> every vid_data and cpu_rdata matches the RAM model, with no misrouted bytes.
